// File: rtl/pcs_scrambler_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pcs_scrambler_pipe
// Purpose  : Self-synchronous 10GBASE-R scrambler/descrambler,
//            G(x) = 1 + x^39 + x^58, processing DATA_WIDTH payload bits per beat.
//            A 2-bit sync header and its qualifier travel alongside the payload
//            untouched. Valid/ready handshake with a one-entry skid buffer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_WIDTH : payload bits per beat (8..64)
//   MODE       : 0 = scramble (TX), 1 = descramble (RX)
//   SEED       : LFSR value loaded on reset
// Ports:
//   i_clk, i_reset_n      : clock, synchronous active-low reset
//   i_data/i_hdr/i_hdr_vld: input beat (bit 0 of i_data is first on the wire)
//   i_valid / o_ready     : upstream handshake (o_ready is a flop output)
//   o_data/o_hdr/o_hdr_vld: output beat
//   o_valid / i_ready     : downstream handshake
//   i_bypass              : (only with PCS_SCRAMBLER_BYPASS_EN) pass beat
//                           unmodified and hold the LFSR
// Optional macro: PCS_SCRAMBLER_BYPASS_EN
// ============================================================================
module pcs_scrambler_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MODE       = 0,
   parameter logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [1:0]            i_hdr,
   input  logic                  i_hdr_vld,
   input  logic                  i_valid,
`ifdef PCS_SCRAMBLER_BYPASS_EN
   input  logic                  i_bypass,
`endif
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_hdr,
   output logic                  o_hdr_vld,
   output logic                  o_valid,
   input  logic                  i_ready
);

   // LFSR state
   logic [57:0]           lfsr_q;
   logic [57:0]           lfsr_d;

   // Main output register (M)
   logic                  m_vld_q,     m_vld_d;
   logic [DATA_WIDTH-1:0] m_data_q,    m_data_d;
   logic [1:0]            m_hdr_q,     m_hdr_d;
   logic                  m_hdr_vld_q, m_hdr_vld_d;

   // Skid register (K)
   logic                  k_vld_q,     k_vld_d;
   logic [DATA_WIDTH-1:0] k_data_q,    k_data_d;
   logic [1:0]            k_hdr_q,     k_hdr_d;
   logic                  k_hdr_vld_q, k_hdr_vld_d;

   logic                  ready_q,     ready_d;

   // Scrambler datapath results for the beat currently on the inputs
   logic [57:0]           scr_lfsr_d;
   logic [DATA_WIDTH-1:0] scr_data_d;
   logic                  scr_bit_d;
   logic [57:0]           beat_lfsr_d;
   logic [DATA_WIDTH-1:0] beat_data_d;

   logic                  in_xfer_d;
   logic                  out_xfer_d;

   assign in_xfer_d  = i_valid && ready_q;
   assign out_xfer_d = m_vld_q && i_ready;

   // Bit-serial recurrence unrolled across the beat. The feedback bit is the
   // scrambled bit on TX and the received (scrambled) bit on RX, which is
   // what makes the RX side self-synchronising.
   always_comb begin
      scr_lfsr_d = lfsr_q;
      scr_data_d = '0;
      scr_bit_d  = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         scr_bit_d     = i_data[i] ^ scr_lfsr_d[38] ^ scr_lfsr_d[57];
         scr_data_d[i] = scr_bit_d;
         scr_lfsr_d    = {scr_lfsr_d[56:0], (MODE == 0) ? scr_bit_d : i_data[i]};
      end
   end

`ifdef PCS_SCRAMBLER_BYPASS_EN
   // Bypassed beats leave the LFSR exactly where it was.
   assign beat_data_d = i_bypass ? i_data : scr_data_d;
   assign beat_lfsr_d = i_bypass ? lfsr_q : scr_lfsr_d;
`else
   assign beat_data_d = scr_data_d;
   assign beat_lfsr_d = scr_lfsr_d;
`endif

   // Storage next-state. While K holds a beat o_ready is low, so an input
   // transfer can never coincide with a K->M move.
   always_comb begin
      lfsr_d      = lfsr_q;
      m_vld_d     = m_vld_q;
      m_data_d    = m_data_q;
      m_hdr_d     = m_hdr_q;
      m_hdr_vld_d = m_hdr_vld_q;
      k_vld_d     = k_vld_q;
      k_data_d    = k_data_q;
      k_hdr_d     = k_hdr_q;
      k_hdr_vld_d = k_hdr_vld_q;

      if (in_xfer_d) begin
         lfsr_d = beat_lfsr_d;
      end

      if (out_xfer_d) begin
         if (k_vld_q) begin
            m_data_d    = k_data_q;
            m_hdr_d     = k_hdr_q;
            m_hdr_vld_d = k_hdr_vld_q;
            k_vld_d     = 1'b0;
         end else if (in_xfer_d) begin
            m_data_d    = beat_data_d;
            m_hdr_d     = i_hdr;
            m_hdr_vld_d = i_hdr_vld;
         end else begin
            m_vld_d     = 1'b0;
         end
      end else if (!m_vld_q) begin
         if (in_xfer_d) begin
            m_vld_d     = 1'b1;
            m_data_d    = beat_data_d;
            m_hdr_d     = i_hdr;
            m_hdr_vld_d = i_hdr_vld;
         end
      end else if (in_xfer_d) begin
         // M is full and held: park the beat in K.
         k_vld_d     = 1'b1;
         k_data_d    = beat_data_d;
         k_hdr_d     = i_hdr;
         k_hdr_vld_d = i_hdr_vld;
      end
   end

   assign ready_d = !k_vld_d;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         lfsr_q      <= SEED;
         m_vld_q     <= 1'b0;
         m_data_q    <= '0;
         m_hdr_q     <= 2'b00;
         m_hdr_vld_q <= 1'b0;
         k_vld_q     <= 1'b0;
         k_data_q    <= '0;
         k_hdr_q     <= 2'b00;
         k_hdr_vld_q <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         lfsr_q      <= lfsr_d;
         m_vld_q     <= m_vld_d;
         m_data_q    <= m_data_d;
         m_hdr_q     <= m_hdr_d;
         m_hdr_vld_q <= m_hdr_vld_d;
         k_vld_q     <= k_vld_d;
         k_data_q    <= k_data_d;
         k_hdr_q     <= k_hdr_d;
         k_hdr_vld_q <= k_hdr_vld_d;
         ready_q     <= ready_d;
      end
   end

   assign o_ready   = ready_q;
   assign o_valid   = m_vld_q;
   assign o_data    = m_data_q;
   assign o_hdr     = m_hdr_q;
   assign o_hdr_vld = m_hdr_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_pcs_scrambler_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_scrambler_pipe
// Purpose  : Directed self-checking bench for pcs_scrambler_pipe: reset state,
//            zero-data vectors, idle stability, backpressure/skid behaviour,
//            reset mid-stall, random handshake scoreboard and TX->RX loopback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_scrambler_pipe;

   localparam int unsigned DW   = 32;
   localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [DW-1:0] tx_data;
   logic [1:0]    tx_hdr;
   logic          tx_hvld;
   logic          tx_valid;
   logic          tb_rdy;
   logic          lb;

   logic          tx_o_ready, tx_o_hvld, tx_o_valid;
   logic [DW-1:0] tx_o_data;
   logic [1:0]    tx_o_hdr;
   logic          tx_i_ready;

   logic          rx_i_valid;
   logic          rx_o_ready, rx_o_hvld, rx_o_valid;
   logic [DW-1:0] rx_o_data;
   logic [1:0]    rx_o_hdr;

`ifdef PCS_SCRAMBLER_BYPASS_EN
   logic          tx_bypass;
`endif

   assign tx_i_ready = lb ? rx_o_ready : tb_rdy;
   assign rx_i_valid = lb & tx_o_valid;

   pcs_scrambler_pipe #(.DATA_WIDTH(DW), .MODE(0), .SEED(SEED)) u_tx (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_data    (tx_data),
      .i_hdr     (tx_hdr),
      .i_hdr_vld (tx_hvld),
      .i_valid   (tx_valid),
`ifdef PCS_SCRAMBLER_BYPASS_EN
      .i_bypass  (tx_bypass),
`endif
      .o_ready   (tx_o_ready),
      .o_data    (tx_o_data),
      .o_hdr     (tx_o_hdr),
      .o_hdr_vld (tx_o_hvld),
      .o_valid   (tx_o_valid),
      .i_ready   (tx_i_ready)
   );

   pcs_scrambler_pipe #(.DATA_WIDTH(DW), .MODE(1), .SEED(58'h0)) u_rx (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_data    (tx_o_data),
      .i_hdr     (tx_o_hdr),
      .i_hdr_vld (tx_o_hvld),
      .i_valid   (rx_i_valid),
`ifdef PCS_SCRAMBLER_BYPASS_EN
      .i_bypass  (1'b0),
`endif
      .o_ready   (rx_o_ready),
      .o_data    (rx_o_data),
      .o_hdr     (rx_o_hdr),
      .o_hdr_vld (rx_o_hvld),
      .o_valid   (rx_o_valid),
      .i_ready   (tb_rdy)
   );

   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [57:0]   mlfsr, nlfsr;
   logic [DW-1:0] e_a, e_b, e_c, e_d, rnd;
   logic [34:0]   q[$];
   logic [34:0]   exp35;
   int unsigned   rx_idx;

   // Bit-serial reference scrambler (TX recurrence).
   function automatic logic [DW-1:0] model(input logic [DW-1:0] d,
                                           input logic [57:0] si,
                                           output logic [57:0] so);
      logic [57:0]   s;
      logic [DW-1:0] r;
      logic          b;
      s = si;
      r = '0;
      for (int i = 0; i < DW; i++) begin
         b    = d[i] ^ s[38] ^ s[57];
         r[i] = b;
         s    = {s[56:0], b};
      end
      so = s;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      tx_hdr   = 2'b00;
      tx_hvld  = 1'b0;
      tb_rdy   = 1'b1;
      lb       = 1'b0;
`ifdef PCS_SCRAMBLER_BYPASS_EN
      tx_bypass = 1'b0;
`endif
      step();
      step();
      rst_n = 1'b1;

      // ---- reset state
      chk("rst_valid",   tx_o_valid, 1'b0);
      chk("rst_ready",   tx_o_ready, 1'b1);
      chk("rst_data",    tx_o_data,  '0);
      chk("rst_hdr",     tx_o_hdr,   2'b00);
      chk("rst_hdr_vld", tx_o_hvld,  1'b0);
      mlfsr = SEED;

      // ---- zero data: first beat all zero, second beat bits 7..25 set
      tx_valid = 1'b1; tx_data = '0; tx_hdr = 2'b01; tx_hvld = 1'b1;
      e_a = model(tx_data, mlfsr, nlfsr); mlfsr = nlfsr;
      step();
      chk("zero1_valid", tx_o_valid, 1'b1);
      chk("zero1_data",  tx_o_data,  32'h0000_0000);
      chk("zero1_hdr",   tx_o_hdr,   2'b01);
      chk("zero1_hvld",  tx_o_hvld,  1'b1);
      tx_data = '0; tx_hdr = 2'b10; tx_hvld = 1'b0;
      e_a = model(tx_data, mlfsr, nlfsr); mlfsr = nlfsr;
      step();
      chk("zero2_data",  tx_o_data,  32'h03FF_FF80);
      chk("zero2_hdr",   tx_o_hdr,   2'b10);
      chk("zero2_hvld",  tx_o_hvld,  1'b0);

      // ---- idle with toggling data: no state change
      tx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tx_data = $urandom;
         step();
         chk("idle_valid", tx_o_valid, 1'b0);
      end
      tx_valid = 1'b1; tx_data = 32'hA5A5_5A5A; tx_hdr = 2'b01; tx_hvld = 1'b1;
      e_a = model(tx_data, mlfsr, nlfsr); mlfsr = nlfsr;
      step();
      chk("post_idle_data", tx_o_data, e_a);
      tx_valid = 1'b0;
      step();

      // ---- backpressure: 3 back-to-back beats, i_ready low for 5 cycles
      tb_rdy = 1'b0; tx_valid = 1'b1;
      tx_data = 32'h1111_1111; tx_hdr = 2'b01; tx_hvld = 1'b1;
      e_a = model(tx_data, mlfsr, nlfsr); mlfsr = nlfsr;
      step();
      chk("bp_a_valid", tx_o_valid, 1'b1);
      chk("bp_a_ready", tx_o_ready, 1'b1);
      chk("bp_a_data",  tx_o_data,  e_a);
      tx_data = 32'h2222_2222; tx_hdr = 2'b10; tx_hvld = 1'b0;
      e_b = model(tx_data, mlfsr, nlfsr); mlfsr = nlfsr;
      step();
      chk("bp_ready_fall", tx_o_ready, 1'b0);
      chk("bp_b_hold",     tx_o_data,  e_a);
      tx_data = 32'h3333_3333; tx_hdr = 2'b11; tx_hvld = 1'b1;
      e_c = model(tx_data, mlfsr, nlfsr); mlfsr = nlfsr;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_stall_ready", tx_o_ready, 1'b0);
         chk("bp_stall_valid", tx_o_valid, 1'b1);
         chk("bp_stall_data",  tx_o_data,  e_a);
         chk("bp_stall_hdr",   {tx_o_hvld, tx_o_hdr}, 3'b101);
      end
      tb_rdy = 1'b1;
      step();
      chk("bp_rel_b_data",  tx_o_data,  e_b);
      chk("bp_rel_b_hdr",   {tx_o_hvld, tx_o_hdr}, 3'b010);
      chk("bp_rel_ready",   tx_o_ready, 1'b1);
      step();
      chk("bp_rel_c_data",  tx_o_data,  e_c);
      chk("bp_rel_c_hdr",   {tx_o_hvld, tx_o_hdr}, 3'b111);
      tx_valid = 1'b0;
      step();
      chk("bp_empty", tx_o_valid, 1'b0);

      // ---- reset mid-stall with M and K full
      tb_rdy = 1'b0; tx_valid = 1'b1;
      tx_data = 32'h4444_4444;
      step();
      tx_data = 32'h5555_5555;
      step();
      chk("rms_pre_ready", tx_o_ready, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; tx_valid = 1'b0;
      chk("rms_valid", tx_o_valid, 1'b0);
      chk("rms_ready", tx_o_ready, 1'b1);
      chk("rms_data",  tx_o_data,  '0);
      mlfsr = SEED;
      tb_rdy = 1'b1; tx_valid = 1'b1; tx_data = '0; tx_hdr = 2'b01; tx_hvld = 1'b1;
      e_d = model(tx_data, mlfsr, nlfsr); mlfsr = nlfsr;
      step();
      chk("rms_zero_valid", tx_o_valid, 1'b1);
      chk("rms_zero_data",  tx_o_data,  32'h0000_0000);
      tx_valid = 1'b0;
      step();

`ifdef PCS_SCRAMBLER_BYPASS_EN
      // ---- bypass beats interleaved with scrambled beats
      tb_rdy = 1'b1; tx_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tx_bypass = i[0];
         rnd       = $urandom;
         tx_data   = i[0] ? 32'hDEAD_BEEF : rnd;
         tx_hdr    = i[1:0]; tx_hvld = 1'b1;
         if (tx_bypass) begin
            e_a = 32'hDEAD_BEEF;
         end else begin
            e_a = model(tx_data, mlfsr, nlfsr); mlfsr = nlfsr;
         end
         step();
         chk("byp_data", tx_o_data, e_a);
      end
      tx_valid = 1'b0; tx_bypass = 1'b0;
      step();
`endif

      // ---- random valid (70%) / ready (50%) against the reference model
      for (int c = 0; c < 2000; c++) begin
         tx_valid = ($urandom_range(0, 99) < 70);
         tx_data  = $urandom;
         tx_hdr   = 2'($urandom_range(0, 3));
         tx_hvld  = 1'($urandom_range(0, 1));
         tb_rdy   = ($urandom_range(0, 1) == 1);
         if (tx_o_valid && tb_rdy) begin
            if (q.size() == 0) begin
               chk("sb_extra_beat", tx_o_valid, 1'b0);
            end else begin
               exp35 = q.pop_front();
               chk("sb_beat", {tx_o_hvld, tx_o_hdr, tx_o_data}, exp35);
            end
         end
         if (tx_valid && tx_o_ready) begin
            e_a = model(tx_data, mlfsr, nlfsr); mlfsr = nlfsr;
            q.push_back({tx_hvld, tx_hdr, e_a});
         end
         step();
      end
      tx_valid = 1'b0; tb_rdy = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (tx_o_valid) begin
            if (q.size() == 0) begin
               chk("sb_drain_extra", tx_o_valid, 1'b0);
            end else begin
               exp35 = q.pop_front();
               chk("sb_drain_beat", {tx_o_hvld, tx_o_hdr, tx_o_data}, exp35);
            end
         end
         step();
      end
      chk("sb_left_over", q.size(), 0);
      chk("sb_idle", tx_o_valid, 1'b0);

      // ---- loopback TX -> RX (RX seeded with zero); payload checked after 2 beats
      lb = 1'b1; rx_idx = 0;
      for (int c = 0; c < 1500; c++) begin
         tx_valid = ($urandom_range(0, 99) < 70);
         tx_data  = $urandom;
         tx_hdr   = 2'($urandom_range(0, 3));
         tx_hvld  = 1'($urandom_range(0, 1));
         tb_rdy   = ($urandom_range(0, 1) == 1);
         if (rx_o_valid && tb_rdy) begin
            if (q.size() == 0) begin
               chk("lb_extra_beat", rx_o_valid, 1'b0);
            end else begin
               exp35 = q.pop_front();
               chk("lb_hdr", {rx_o_hvld, rx_o_hdr}, exp35[34:32]);
               if (rx_idx >= 2) chk("lb_data", rx_o_data, exp35[31:0]);
               rx_idx++;
            end
         end
         if (tx_valid && tx_o_ready) q.push_back({tx_hvld, tx_hdr, tx_data});
         step();
      end
      tx_valid = 1'b0; tb_rdy = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (rx_o_valid) begin
            if (q.size() == 0) begin
               chk("lb_drain_extra", rx_o_valid, 1'b0);
            end else begin
               exp35 = q.pop_front();
               chk("lb_drain_hdr", {rx_o_hvld, rx_o_hdr}, exp35[34:32]);
               if (rx_idx >= 2) chk("lb_drain_data", rx_o_data, exp35[31:0]);
               rx_idx++;
            end
         end
         step();
      end
      chk("lb_left_over", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pcs_scrambler_pipe.md
Name: pcs_scrambler_pipe

Overview:
- Parametrised successor to the single-mode 10GBASE-R scrambler. Implements the self-synchronous scrambler or descrambler of IEEE 802.3 Clause 49.2.6, G(x) = 1 + x^39 + x^58, selected at elaboration time.
- Processes DATA_WIDTH payload bits per beat.
- Passes a 2-bit sync header unscrambled, alongside the payload.
- Uses a full valid/ready handshake with a skid buffer, so backpressure never drops or duplicates data.
- Sits between the 64b/66b encoder and the TX gearbox when MODE=0, or between the RX gearbox and the decoder when MODE=1.

Parameters:
- DATA_WIDTH, 32: payload bits per beat. Legal values are 8..64.
- MODE, 0: 0 = scramble (TX), 1 = descramble (RX).
- SEED, 58'h3FF_FFFF_FFFF_FFFF: LFSR value loaded on reset.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous, active-low reset
- i_data  in  DATA_WIDTH  payload; bit 0 is first on the wire
- i_hdr  in  2  sync header, passed through untouched
- i_hdr_vld  in  1  beat carries a header (start of a 66-bit block)
- i_valid  in  1  upstream beat valid
- o_ready  out  1  block can accept a beat; registered
- o_data  out  DATA_WIDTH  scrambled or descrambled payload
- o_hdr  out  2  delayed copy of i_hdr
- o_hdr_vld  out  1  delayed copy of i_hdr_vld
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready

Behaviour:
- Transfer rules:
  - An input transfer happens when i_valid && o_ready.
  - An output transfer happens when o_valid && i_ready.
- Bit recurrence, for i = 0..DATA_WIDTH-1 using a running copy s of the LFSR:
  - out[i] = in[i] ^ s[38] ^ s[57].
  - Then s = {s[56:0], fb}.
  - fb = out[i] when MODE=0; fb = in[i] when MODE=1.
- LFSR update:
  - The LFSR commits the final s only on an input transfer.
  - Stalled beats never advance the LFSR.
- Header handling: i_hdr and i_hdr_vld never enter the LFSR and are never XORed.
- Storage: a main output register (M) plus one skid register (K).
  - o_ready = K empty, registered.
  - Input transfer with M empty, or with M being consumed this cycle: the beat is written to M.
  - Input transfer with M full and i_ready=0: the beat is written to K, and o_ready falls next cycle.
  - When M is consumed and K is full: K moves to M, K empties, and o_ready rises next cycle.
  - Input transfer and output transfer in the same cycle with K empty: M is replaced; occupancy is unchanged.
- Latency: 1 cycle from input transfer to o_valid, when unstalled.
- Throughput: 1 beat/cycle sustained with i_ready=1.
- Output stability:
  - o_valid=1 with i_ready=0: o_data, o_hdr and o_hdr_vld hold stable until the transfer.
  - No output combinationally depends on i_valid or i_ready.
- Reset (synchronous, dominant over all other activity, including mid-stall):
  - LFSR=SEED, M and K empty.
  - o_valid=0, o_ready=1, o_data=0, o_hdr=0, o_hdr_vld=0.
  - Any beat held in M or K at reset is discarded.
- Seed dependence:
  - MODE=1 output is independent of SEED after 58 input bits (self-synchronisation).
  - MODE=0 output depends on SEED permanently.
- i_valid=0 with i_data toggling: no state change.

Optional Feature:
- Macro: PCS_SCRAMBLER_BYPASS_EN.
- When defined:
  - Adds input port i_bypass (1 bit), which is sampled per beat at input transfer.
  - Beats accepted with i_bypass=1 pass i_data unmodified and do not advance the LFSR.
  - Beats accepted with i_bypass=0 behave normally.
- When undefined:
  - No port exists.
  - The block always scrambles or descrambles.

Test Plan:
- Zero data, MODE=0, DATA_WIDTH=32, SEED all ones: reset, then feed 32'h0000_0000 for one beat -> o_data=32'h0000_0000 one cycle after acceptance, since taps 38 and 57 stay 1 for the first 39 bits. Second zero beat -> o_data bit 7 = 1.
- Loopback: MODE=0 instance feeds a MODE=1 instance (SEED=58'h0 on the RX side), 1000 random beats -> RX o_data equals TX i_data for every beat after the first 2 beats (58 bits); headers match on every beat.
- Backpressure: hold i_ready=0 for 5 cycles while driving 3 back-to-back beats ->
  - o_ready falls after the 2nd accepted beat.
  - o_data is stable for the whole stall.
  - After release, beats emerge in order, with no loss or duplication.
  - Output matches the unstalled golden model.
- Random valid/ready: i_valid 70%, i_ready 50% duty, 10k beats -> scoreboard vs bit-serial reference model; every accepted beat appears exactly once, in order.
- Reset mid-stall: M and K full, assert i_reset_n=0 for 1 cycle -> next cycle o_valid=0, o_ready=1; the first post-reset beat of zeros yields 32'h0000_0000.
- With PCS_SCRAMBLER_BYPASS_EN: interleave bypass beats with 32'hDEAD_BEEF -> those beats are output as 32'hDEAD_BEEF; the scrambled stream around them matches a model that skips the bypass beats.
